// File: rtl/narrow_16.sv
// Narrows a 16-bit word to val_width bits (signed or unsigned, truncate or saturate)
// behind a 2-entry in-order FIFO with a sticky overflow flag.
module narrow_16 #(
    parameter int val_width = 4
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          val,
    input  logic                 zero_sign,
    input  logic                 sat_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [val_width-1:0] val_nar,
    output logic                 ovf,
    output logic                 ovf_sticky,
    input  logic                 ovf_clr
);

    // Returns {narrowed value, overflow}.
    function automatic logic [val_width:0] narrow(input logic [15:0] v,
                                                  input logic sgn,
                                                  input logic sat);
        logic signed [15:0]   sv;
        logic signed [15:0]   sh;
        logic                 fit;
        logic [val_width-1:0] res;
        sv  = v;
        sh  = sv >>> (val_width - 1);
        if (sgn) begin
            fit = (sh == 16'sd0) || (sh == -16'sd1);
        end else begin
            fit = ((v >> val_width) == 16'd0);
        end
        res = v[val_width-1:0];
        if (!fit && sat) begin
            if (sgn) begin
                res = {v[15], {(val_width-1){~v[15]}}};
            end else begin
                res = '1;
            end
        end
        return {res, ~fit};
    endfunction

    logic [1:0]           r_count;
    logic                 r_rdy_en;
    logic [val_width-1:0] r_head_val;
    logic                 r_head_ovf;
    logic [val_width-1:0] r_skid_val;
    logic                 r_skid_ovf;
    logic                 r_sticky;

    logic [val_width:0]   w_nar;
    logic                 w_push;
    logic                 w_pop;

    assign w_nar      = narrow(val, zero_sign, sat_en);
    // r_rdy_en keeps in_ready low until the first edge after reset release.
    assign in_ready   = r_rdy_en && (r_count < 2'd2);
    assign out_valid  = (r_count != 2'd0);
    assign w_push     = in_valid && in_ready;
    assign w_pop      = out_valid && out_ready;
    assign val_nar    = r_head_val;
    assign ovf        = r_head_ovf;
    assign ovf_sticky = r_sticky;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_count    <= 2'd0;
            r_rdy_en   <= 1'b0;
            r_head_val <= '0;
            r_head_ovf <= 1'b0;
            r_skid_val <= '0;
            r_skid_ovf <= 1'b0;
            r_sticky   <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_push && w_nar[0]) begin
                r_sticky <= 1'b1;
            end else if (ovf_clr) begin
                r_sticky <= 1'b0;
            end
            // Head register holds its value when the FIFO drains to empty.
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head_val <= w_nar[val_width:1];
                        r_head_ovf <= w_nar[0];
                    end else begin
                        r_skid_val <= w_nar[val_width:1];
                        r_skid_ovf <= w_nar[0];
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_head_val <= r_skid_val;
                        r_head_ovf <= r_skid_ovf;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    r_head_val <= w_nar[val_width:1];
                    r_head_ovf <= w_nar[0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_narrow_16.sv
// Directed bench for narrow_16 (val_width = 4): vector table plus FIFO, sticky and reset sequences.
module tb_narrow_16;

    logic        clock;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] val;
    logic        zero_sign;
    logic        sat_en;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  val_nar;
    logic        ovf;
    logic        ovf_sticky;
    logic        ovf_clr;

    int checks = 0;
    int errors = 0;

    narrow_16 #(.val_width(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .val        (val),
        .zero_sign  (zero_sign),
        .sat_en     (sat_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .val_nar    (val_nar),
        .ovf        (ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] v;
        logic        zs;
        logic        sat;
        logic [3:0]  nar;
        logic        ov;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic edge_wait();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_sticky;
        tbl[0]  = '{16'hFFF9, 1'b1, 1'b0, 4'h9, 1'b0};
        tbl[1]  = '{16'h0009, 1'b1, 1'b1, 4'h7, 1'b1};
        tbl[2]  = '{16'hFF00, 1'b1, 1'b1, 4'h8, 1'b1};
        tbl[3]  = '{16'h0012, 1'b0, 1'b0, 4'h2, 1'b1};
        tbl[4]  = '{16'h0012, 1'b0, 1'b1, 4'hF, 1'b1};
        tbl[5]  = '{16'h0007, 1'b1, 1'b1, 4'h7, 1'b0};
        tbl[6]  = '{16'hFFF8, 1'b1, 1'b1, 4'h8, 1'b0};
        tbl[7]  = '{16'h000F, 1'b0, 1'b1, 4'hF, 1'b0};
        tbl[8]  = '{16'h8000, 1'b1, 1'b0, 4'h0, 1'b1};
        tbl[9]  = '{16'h7FFF, 1'b1, 1'b1, 4'h7, 1'b1};
        tbl[10] = '{16'h0010, 1'b0, 1'b0, 4'h0, 1'b1};
        tbl[11] = '{16'hFFF7, 1'b1, 1'b1, 4'h8, 1'b1};

        resetn = 1'b0; in_valid = 1'b0; val = '0; zero_sign = 1'b0;
        sat_en = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;

        // Reset state
        #22;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sticky", ovf_sticky, 0);
        chk("rst_val_nar", val_nar, 0);
        chk("rst_ovf", ovf, 0);
        #1 resetn = 1'b1;
        #1 chk("in_ready_before_edge", in_ready, 0);
        edge_wait();
        chk("in_ready_after_edge", in_ready, 1);

        // Table: push one word, check head next cycle, then pop it
        exp_sticky = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            val = tbl[i].v; zero_sign = tbl[i].zs; sat_en = tbl[i].sat;
            in_valid = 1'b1; out_ready = 1'b0;
            chk($sformatf("v%0d_empty_before", i), out_valid, 0);
            edge_wait();
            exp_sticky = exp_sticky | tbl[i].ov;
            chk($sformatf("v%0d_out_valid", i), out_valid, 1);
            chk($sformatf("v%0d_val_nar", i), val_nar, tbl[i].nar);
            chk($sformatf("v%0d_ovf", i), ovf, tbl[i].ov);
            chk($sformatf("v%0d_sticky", i), ovf_sticky, exp_sticky);
            @(negedge clock);
            in_valid = 1'b0; out_ready = 1'b1;
            edge_wait();
            chk($sformatf("v%0d_drained", i), out_valid, 0);
            chk($sformatf("v%0d_hold_val", i), val_nar, tbl[i].nar);
        end

        // Backpressure: three offered, two accepted, drain in order
        @(negedge clock);
        out_ready = 1'b0; zero_sign = 1'b0; sat_en = 1'b0;
        in_valid = 1'b1; val = 16'h0001;
        edge_wait();
        @(negedge clock) val = 16'h0002;
        edge_wait();
        chk("bp_full_in_ready", in_ready, 0);
        @(negedge clock) val = 16'h0003;
        edge_wait();
        chk("bp_still_full", in_ready, 0);
        chk("bp_head_first", val_nar, 4'h1);
        chk("bp_out_valid", out_valid, 1);
        @(negedge clock) out_ready = 1'b1;
        edge_wait();
        chk("bp_head_second", val_nar, 4'h2);
        chk("bp_ready_after_pop", in_ready, 1);
        edge_wait();
        chk("bp_pushpop_head", val_nar, 4'h3);
        chk("bp_pushpop_valid", out_valid, 1);
        @(negedge clock) in_valid = 1'b0;
        edge_wait();
        chk("bp_empty", out_valid, 0);
        chk("bp_hold_last", val_nar, 4'h3);

        // Sticky: set wins over clear, clear alone clears
        @(negedge clock) ovf_clr = 1'b1;
        edge_wait();
        chk("sticky_cleared", ovf_sticky, 0);
        @(negedge clock);
        val = 16'h0012; zero_sign = 1'b0; sat_en = 1'b0; in_valid = 1'b1;
        out_ready = 1'b0; ovf_clr = 1'b1;
        edge_wait();
        chk("sticky_set_wins", ovf_sticky, 1);
        @(negedge clock);
        in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b1;
        edge_wait();
        chk("sticky_clr_later", ovf_sticky, 0);
        @(negedge clock) ovf_clr = 1'b0;

        // Asynchronous reset with two entries buffered
        @(negedge clock);
        out_ready = 1'b0; in_valid = 1'b1; val = 16'h0005;
        edge_wait();
        edge_wait();
        chk("ar_full", in_ready, 0);
        in_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_in_ready", in_ready, 0);
        chk("ar_val_nar", val_nar, 0);
        #2 resetn = 1'b1;
        edge_wait();
        chk("ar_ready_back", in_ready, 1);
        chk("ar_still_empty", out_valid, 0);
        @(negedge clock);
        val = 16'h0003; zero_sign = 1'b0; sat_en = 1'b0; in_valid = 1'b1;
        edge_wait();
        chk("ar_first_valid", out_valid, 1);
        chk("ar_first_val", val_nar, 4'h3);
        chk("ar_first_ovf", ovf, 0);
        @(negedge clock) in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
